// File: rtl/hvtx_pkg.sv
// hvtx_pkg: shared TMDS symbol constants, preamble timing and types
package hvtx_pkg;
  typedef logic [9:0] sym_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_GUARD} pre_st_e;
  localparam sym_t CTL00 = 10'b1101010100;
  localparam sym_t CTL01 = 10'b0010101011;
  localparam sym_t CTL10 = 10'b0101010100;
  localparam sym_t CTL11 = 10'b1010101011;
  localparam sym_t GB_C0C2 = 10'b1011001100;
  localparam sym_t GB_C1 = 10'b0100110011;
  localparam int PRE_LEN = 8;
  localparam int GB_LEN = 2;
  function automatic sym_t ctl_sym(input logic [1:0] c);
    return c == 2'b00 ? CTL00 : c == 2'b01 ? CTL01 : c == 2'b10 ? CTL10 : CTL11;
  endfunction
endpackage

// File: rtl/hvtx_tmds_chan.sv
// hvtx_tmds_chan: one TMDS channel, 2-stage pipeline with running disparity
module hvtx_tmds_chan import hvtx_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       de,
  input  logic [1:0] ctl,
  input  logic       ovr_vld,
  input  sym_t       ovr_sym,
  output sym_t       sym
);
  logic [3:0] n1d, n1q;
  logic xnr, par, de1, ov1;
  logic [8:0] qm_c, qm;
  logic [1:0] ctl1;
  sym_t ovs1, sym_n;
  logic signed [4:0] cnt, cnt_n, dif;
  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d += 4'(data[i]);
    xnr = n1d > 4'd4 || (n1d == 4'd4 && !data[0]);
    par = data[0];
    qm_c[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      par ^= data[i];
      qm_c[i] = par ^ (xnr & i[0]);
    end
    qm_c[8] = ~xnr;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      qm <= '0;
      de1 <= 1'b0;
      ctl1 <= 2'b00;
      ov1 <= 1'b0;
      ovs1 <= '0;
    end else begin
      qm <= qm_c;
      de1 <= de;
      ctl1 <= ctl;
      ov1 <= ovr_vld;
      ovs1 <= ovr_sym;
    end
  // dif = N1 - N0 of q_m[7:0]; non-video cycles clear the running disparity
  always_comb begin
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q += 4'(qm[i]);
    dif = $signed({n1q, 1'b0} - 5'd8);
    sym_n = ov1 ? ovs1 : ctl_sym(ctl1);
    cnt_n = '0;
    if (de1) begin
      if (cnt == '0 || dif == '0) begin
        sym_n = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt_n = qm[8] ? cnt + dif : cnt - dif;
      end else if (cnt[4] == dif[4]) begin
        sym_n = {1'b1, qm[8], ~qm[7:0]};
        cnt_n = cnt + {3'b000, qm[8], 1'b0} - dif;
      end else begin
        sym_n = {1'b0, qm[8], qm[7:0]};
        cnt_n = cnt - {3'b000, ~qm[8], 1'b0} + dif;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sym <= CTL00;
      cnt <= '0;
    end else begin
      sym <= sym_n;
      cnt <= cnt_n;
    end
endmodule

// File: rtl/hvtx_tmds_enc.sv
// hvtx_tmds_enc: multi-channel TMDS encoder with optional HDMI preamble/guard insertion
module hvtx_tmds_enc import hvtx_pkg::*; #(
  parameter int NCH = 3,
  parameter int HDMI_MODE = 0,
  parameter int LA = 10
) (
  input  logic                  i_pclk,
  input  logic                  i_rst_n,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [NCH*8-1:0]      i_video,
  output logic [NCH-1:0][9:0]   o_chan_vec,
  output logic                  o_de
);
  logic hs_d, vs_d, de_d, pre, guard, de_s1;
  logic [NCH*8-1:0] video_d;
  if (NCH < 1 || (HDMI_MODE != 0 && (NCH != 3 || LA != PRE_LEN + GB_LEN))) begin : g_bad
    $error("hvtx_tmds_enc: invalid NCH/HDMI_MODE/LA combination");
  end
  if (HDMI_MODE != 0) begin : g_hdmi
    logic [LA-1:0][NCH*8+2:0] dl;
    pre_st_e st, st_n;
    logic [4:0] cnt, cnt_n;
    logic de_p, rise;
    assign rise = i_de & ~de_p;
    assign {hs_d, vs_d, de_d, video_d} = dl[LA-1];
    always_ff @(posedge i_pclk or negedge i_rst_n)
      if (!i_rst_n) begin
        dl <= '0;
        st <= ST_IDLE;
        cnt <= '0;
        de_p <= 1'b0;
      end else begin
        dl <= {dl[LA-2:0], i_hs, i_vs, i_de, i_video};
        st <= st_n;
        cnt <= cnt_n;
        de_p <= i_de;
      end
    // the trigger cycle itself is preamble slot 0, so insertion lands in the 10 delayed cycles before the pixel
    always_comb begin
      st_n = st;
      cnt_n = cnt + 5'd1;
      pre = st == ST_PRE || (st == ST_IDLE && rise);
      guard = st == ST_GUARD;
      if (st == ST_IDLE) begin
        st_n = rise ? ST_PRE : ST_IDLE;
        cnt_n = rise ? 5'd1 : 5'd0;
      end else if (st == ST_PRE) begin
        st_n = cnt == 5'(PRE_LEN - 1) ? ST_GUARD : ST_PRE;
      end else begin
        st_n = cnt == 5'(PRE_LEN + GB_LEN - 1) ? ST_IDLE : ST_GUARD;
        cnt_n = cnt == 5'(PRE_LEN + GB_LEN - 1) ? 5'd0 : cnt + 5'd1;
      end
    end
  end else begin : g_dvi
    assign {hs_d, vs_d, de_d, video_d} = {i_hs, i_vs, i_de, i_video};
    assign pre = 1'b0;
    assign guard = 1'b0;
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    hvtx_tmds_chan u_ch (
      .clk     (i_pclk),
      .rst_n   (i_rst_n),
      .data    (video_d[8*k +: 8]),
      .de      (de_d),
      .ctl     (k == 0 ? {vs_d, hs_d} : (k == 1 && pre) ? 2'b01 : 2'b00),
      .ovr_vld (guard),
      .ovr_sym (k == 1 ? GB_C1 : GB_C0C2),
      .sym     (o_chan_vec[k])
    );
  end
  always_ff @(posedge i_pclk or negedge i_rst_n)
    if (!i_rst_n) begin
      de_s1 <= 1'b0;
      o_de <= 1'b0;
    end else begin
      de_s1 <= de_d;
      o_de <= de_s1;
    end
endmodule

// File: tb/tb_hvtx_tmds_enc.sv
// tb_hvtx_tmds_enc: directed checks of DVI and HDMI instances of hvtx_tmds_enc
module tb_hvtx_tmds_enc;
  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] G02 = 10'h2CC;
  localparam logic [9:0] G1 = 10'h133;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_hs = 1'b0, d_vs = 1'b0, d_de = 1'b0, d_ode;
  logic h_hs = 1'b1, h_vs = 1'b0, h_de = 1'b0, h_ode;
  logic [23:0] d_vid = '0, h_vid = 24'hFF5500;
  logic [2:0][9:0] d_sym, h_sym;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hvtx_tmds_enc #(.NCH(3), .HDMI_MODE(0), .LA(10)) u_dvi (
    .i_pclk(clk), .i_rst_n(rst_n), .i_hs(d_hs), .i_vs(d_vs), .i_de(d_de),
    .i_video(d_vid), .o_chan_vec(d_sym), .o_de(d_ode));
  hvtx_tmds_enc #(.NCH(3), .HDMI_MODE(1), .LA(10)) u_hdmi (
    .i_pclk(clk), .i_rst_n(rst_n), .i_hs(h_hs), .i_vs(h_vs), .i_de(h_de),
    .i_video(h_vid), .o_chan_vec(h_sym), .o_de(h_ode));
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  initial begin
    repeat (3) tick();
    check("rst_d_ch0", d_sym[0], C00);
    check("rst_d_ode", {9'b0, d_ode}, 10'd0);
    check("rst_h_ch1", h_sym[1], C00);
    rst_n = 1'b1;
    d_hs = 1'b1;
    tick(); tick();
    check("dvi_hs_ch0", d_sym[0], C01);
    check("dvi_hs_ch1", d_sym[1], C00);
    check("dvi_hs_ch2", d_sym[2], C00);
    check("dvi_hs_ode", {9'b0, d_ode}, 10'd0);
    d_hs = 1'b0; d_vs = 1'b1;
    tick(); tick();
    check("dvi_vs_ch0", d_sym[0], C10);
    d_hs = 1'b1;
    tick(); tick();
    check("dvi_hsvs_ch0", d_sym[0], C11);
    d_hs = 1'b0; d_vs = 1'b0;
    tick();
    d_de = 1'b1; d_vid = 24'hFF5500;
    tick(); tick();
    check("dvi_p1_ch0", d_sym[0], 10'h100);
    check("dvi_p1_ch1", d_sym[1], 10'h133);
    check("dvi_p1_ch2", d_sym[2], 10'h200);
    check("dvi_p1_ode", {9'b0, d_ode}, 10'd1);
    d_vid = 24'h555500;
    tick();
    check("dvi_p2_ch0", d_sym[0], 10'h3FF);
    check("dvi_p2_ch2", d_sym[2], 10'h0FF);
    d_de = 1'b0; d_vid = '0;
    tick();
    check("dvi_p3_ch0", d_sym[0], 10'h100);
    check("dvi_p3_ch2_tie", d_sym[2], 10'h133);
    d_de = 1'b1; d_vid = 24'hFF5500;
    tick();
    check("dvi_blank_ch0", d_sym[0], C00);
    check("dvi_blank_ode", {9'b0, d_ode}, 10'd0);
    tick();
    check("dvi_p4_ch0", d_sym[0], 10'h100);
    check("dvi_p4_ch2", d_sym[2], 10'h200);
    d_de = 1'b0; d_vid = '0;
    tick(); tick();
    for (int t = 0; t < 100; t++) begin
      h_de = (t >= 20 && t <= 35) || (t >= 40 && t <= 55) || (t >= 80 && t <= 81) || (t >= 83 && t <= 90);
      tick();
      case (t)
        20: check("h20_ch1_idle", h_sym[1], C00);
        21: begin
          check("h21_ch1_pre", h_sym[1], C01);
          check("h21_ch2_pre", h_sym[2], C00);
          check("h21_ch0_pre", h_sym[0], C01);
        end
        28: check("h28_ch1_pre", h_sym[1], C01);
        29: begin
          check("h29_ch0_gb", h_sym[0], G02);
          check("h29_ch1_gb", h_sym[1], G1);
          check("h29_ch2_gb", h_sym[2], G02);
          check("h29_ode", {9'b0, h_ode}, 10'd0);
        end
        30: check("h30_ch1_gb", h_sym[1], G1);
        31: begin
          check("h31_ch0_pix", h_sym[0], 10'h100);
          check("h31_ch1_pix", h_sym[1], 10'h133);
          check("h31_ch2_pix", h_sym[2], 10'h200);
          check("h31_ode", {9'b0, h_ode}, 10'd1);
        end
        32: begin
          check("h32_ch0_pix", h_sym[0], 10'h3FF);
          check("h32_ch2_pix", h_sym[2], 10'h0FF);
        end
        41: begin
          check("h41_ch0_keep", h_sym[0], 10'h3FF);
          check("h41_ch2_keep", h_sym[2], 10'h200);
          check("h41_ode", {9'b0, h_ode}, 10'd1);
        end
        46: check("h46_ode", {9'b0, h_ode}, 10'd1);
        47: begin
          check("h47_ch1_pre", h_sym[1], C01);
          check("h47_ch2_pre", h_sym[2], C00);
          check("h47_ode", {9'b0, h_ode}, 10'd0);
        end
        49: check("h49_ch0_gb", h_sym[0], G02);
        50: check("h50_ch1_gb", h_sym[1], G1);
        51: begin
          check("h51_ch0_pix", h_sym[0], 10'h100);
          check("h51_ch2_pix", h_sym[2], 10'h200);
          check("h51_ode", {9'b0, h_ode}, 10'd1);
        end
        67: begin
          check("h67_ch0_ctl", h_sym[0], C01);
          check("h67_ch1_ctl", h_sym[1], C00);
          check("h67_ch2_ctl", h_sym[2], C00);
          check("h67_ode", {9'b0, h_ode}, 10'd0);
        end
        85: check("h85_ch1_pre", h_sym[1], C01);
        90: check("h90_ch2_gb", h_sym[2], G02);
        91: check("h91_ch0_pix", h_sym[0], 10'h100);
        92: check("h92_ch0_pix", h_sym[0], 10'h3FF);
        93: begin
          check("h93_ch1_noretrig", h_sym[1], C00);
          check("h93_ch2_noretrig", h_sym[2], C00);
          check("h93_ode", {9'b0, h_ode}, 10'd0);
        end
        94: begin
          check("h94_ch0_pix", h_sym[0], 10'h100);
          check("h94_ode", {9'b0, h_ode}, 10'd1);
        end
        default: ;
      endcase
    end
    d_de = 1'b1; d_vid = '0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_d_ch0", d_sym[0], C00);
    check("arst_d_ch2", d_sym[2], C00);
    check("arst_d_ode", {9'b0, d_ode}, 10'd0);
    check("arst_h_ch1", h_sym[1], C00);
    tick();
    rst_n = 1'b1;
    tick();
    check("rel_d_ch0", d_sym[0], C00);
    check("rel_d_ode", {9'b0, d_ode}, 10'd0);
    tick();
    check("rel_p1_ch0", d_sym[0], 10'h100);
    check("rel_p1_ode", {9'b0, d_ode}, 10'd1);
    tick();
    check("rel_p2_ch0", d_sym[0], 10'h3FF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hvtx_tmds_enc.md
Name: hvtx_tmds_enc

Overview:
- Parametrised multi-channel TMDS encoder. It is the next generation of the fixed three-channel DVI modulator.
- Sits between the pixel source (hs/vs/de/video) and the 10:1 serialiser, in the pixel clock domain.
- Adds a selectable HDMI mode that inserts the 8-cycle video preamble and 2-cycle video guard band ahead of every active line. It uses an input lookahead delay line to do this.
- Encoding is pipelined, with a per-channel running-disparity counter.

Parameters:
- NCH, 3: number of TMDS data channels. Must be ≥1. HDMI_MODE=1 requires NCH==3; enforce with an elaboration assertion.
- HDMI_MODE, 0: 0 = DVI (control/video only); 1 = HDMI video preamble + guard band insertion.
- LA, 10: lookahead depth in cycles, used only when HDMI_MODE=1. Fixed at 10 (8 preamble + 2 guard); any other value is an elaboration error.

Ports:
- i_pclk, in, 1: pixel clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_hs, in, 1: horizontal sync; CTL bit 0 of channel 0.
- i_vs, in, 1: vertical sync; CTL bit 1 of channel 0.
- i_de, in, 1: data enable (active video).
- i_video, in, NCH*8: pixel data; channel k = bits [8k+7:8k].
- o_chan_vec, out, NCH×10: encoded symbols, packed [NCH-1:0][9:0], bit 0 transmitted first.
- o_de, out, 1: delayed DE aligned with o_chan_vec (high on pixel symbols).

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - o_chan_vec every channel = 10'b1101010100 (CTL 00); o_de=0.
  - Delay line cleared with de=0; disparity counters = 0; preamble FSM = IDLE.
  - Reset mid-line aborts the line; the first cycle after release outputs CTL 00 symbols.
- Latency, inputs → o_chan_vec:
  - DVI: 2 cycles. Stage 1 = ones count + 9-bit q_m; stage 2 = disparity decision + output register.
  - HDMI: LA+2 = 12 cycles. Inputs pass through an LA-deep shift register before stage 1.
- Video symbols (delayed de=1): standard DVI 1.0 TMDS algorithm.
  - XNOR path if N1(d)>4 or (N1(d)==4 and d[0]==0); otherwise XOR.
  - Disparity counter is signed 5-bit. Update rules follow DVI 1.0 exactly, including the cnt==0 / N1==N0 tie case.
- Control symbols (delayed de=0): c={c1,c0} maps as 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - Channel 0: c={vs,hs}.
  - Other channels: c=00, except during the preamble.
  - Disparity counter is forced to 0 on every non-video cycle.
- HDMI preamble FSM, states IDLE → PRE → GUARD → IDLE:
  - Trigger: rising edge of the undelayed i_de while the FSM is IDLE.
  - PRE: 8 cycles. Channel 1 c=01 (CTL0=1), channel 2 c=00; channel 0 keeps {vs,hs}.
  - GUARD: 2 cycles. Channel 0 = 1011001100, channel 1 = 0100110011, channel 2 = 1011001100.
  - The 5-bit preamble/guard counter sits alongside the delay line, so symbol insertion occurs exactly in the 10 delayed cycles before the first pixel.
- Precedence:
  - Delayed de=1 always wins over preamble/guard. With a blanking gap <10 cycles, the overlapped preamble/guard symbols are dropped and the FSM still returns to IDLE on schedule.
  - An i_de rising edge while the FSM is not IDLE is ignored. No re-trigger, no queueing.
- DE falling edge: the next output is a control symbol. No trailing guard band (video period only).
- NCH>3 (DVI only): channels ≥1 use c=00 for control.

Decomposition:
- Package hvtx_pkg:
  - CTL symbol constants (4 × 10-bit);
  - video guard-band constants GB_C0C2=10'b1011001100 and GB_C1=10'b0100110011;
  - PRE_LEN=8 and GB_LEN=2;
  - typedef of the 10-bit symbol and the FSM state enum.
- Sub-module hvtx_tmds_chan:
  - one channel, 2-stage pipeline with its own disparity counter;
  - inputs: data, de, 2-bit ctl, an override-valid flag and a 10-bit override symbol;
  - the top generates NCH instances plus the delay line and preamble FSM.

Test Plan:
- DVI, de=0, hs=1, vs=0 → 2 cycles later ch0=0010101011, ch1=ch2=1101010100, o_de=0.
- DVI, de=1, video ch0=0x00 for 3 consecutive cycles from cnt=0 → ch0 symbols 0x100, 0x3FF, 0x100; internal cnt -8, +2, -6.
- DVI, de toggles 1→0 mid-sequence → the following control cycle resets cnt. A subsequent 0x00 pixel yields 0x100 again.
- HDMI, ≥20 blanking cycles, then i_de rises at cycle n:
  - ch1=0010101011 at cycles n+2..n+9;
  - ch0/ch1/ch2 = 0x2CC/0x133/0x2CC at n+10..n+11;
  - first pixel symbol at n+12 with o_de=1.
- HDMI, blanking gap of 4 cycles between lines → the second line's pixels appear intact with no guard symbols overwriting them. Channel 1 shows preamble code only on the delayed-blank cycles.
- Assert i_rst_n=0 mid-line for 1 cycle → all outputs 1101010100 immediately (async), o_de=0. The next line encodes from cnt=0.
